// File: rtl/pwm_ramp_ctrl.sv
// PWM counter/comparator with a handshake-loaded target duty that is approached
// one LSB per STEP_PERIODS periods, duty changes landing only on period wraps.
module pwm_ramp_ctrl #(
  parameter int WIDTH        = 4,
  parameter int STEP_PERIODS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] tgt_duty,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] duty,
  output logic             busy,
  output logic             period_end,
  output logic             pwm_out
);
  localparam int PW = $clog2(STEP_PERIODS) + 1;

  typedef enum logic {IDLE, RAMP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [WIDTH-1:0] duty_step;

  assign period_end = enable & (cnt_q == {WIDTH{1'b1}});
  assign pwm_out    = enable & (cnt_q < duty_q);
  assign duty       = duty_q;
  assign tgt_ready  = (state_q == IDLE);
  assign busy       = (state_q == RAMP);

  // Target is never beyond the range, so stepping toward it cannot wrap.
  assign duty_step = (target_q > duty_q) ? duty_q + WIDTH'(1) : duty_q - WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    pcnt_d   = pcnt_q;
    cnt_d    = enable ? cnt_q + WIDTH'(1) : '0;
    case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          target_d = tgt_duty;
          pcnt_d   = '0;
          if (tgt_duty != duty_q) state_d = RAMP;
        end
      end
      RAMP: begin
        // Steps coincide with the counter wrap so each period sees one duty.
        if (period_end) begin
          if (pcnt_q == PW'(STEP_PERIODS - 1)) begin
            pcnt_d = '0;
            duty_d = duty_step;
            if (duty_step == target_q) state_d = IDLE;
          end else begin
            pcnt_d = pcnt_q + PW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      duty_q   <= '0;
      target_q <= '0;
      pcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      pcnt_q   <= pcnt_d;
    end
  end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed phase table plus random traffic, every cycle
// checked against a closed-form model (duty = start +/- ends/STEP).
module tb_pwm_ramp_ctrl;
  localparam int W    = 4;
  localparam int STEP = 2;
  localparam int TOP  = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b1;
  logic [W-1:0] tgt_duty = '0;
  logic         tgt_valid = 1'b0;
  logic         tgt_ready, busy, period_end, pwm_out;
  logic [W-1:0] duty;

  int errors = 0;
  int checks = 0;

  pwm_ramp_ctrl #(.WIDTH(W), .STEP_PERIODS(STEP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .tgt_duty(tgt_duty),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .duty(duty), .busy(busy),
    .period_end(period_end), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  // Reference model: counter as cycles-since-enable mod period; duty derived
  // from the number of period ends seen since the request was accepted.
  int m_cnt = 0, m_duty = 0, m_tgt = 0, m_start = 0, m_ends = 0;
  bit m_busy = 0;

  task automatic model_edge();
    int k;
    bit pe;
    if (rst) begin
      m_cnt = 0; m_duty = 0; m_tgt = 0; m_start = 0; m_ends = 0; m_busy = 0;
    end else begin
      pe = enable && (m_cnt == TOP);
      if (!m_busy) begin
        if (tgt_valid) begin
          m_tgt = int'(tgt_duty);
          if (m_tgt != m_duty) begin
            m_busy = 1; m_start = m_duty; m_ends = 0;
          end
        end
      end else if (pe) begin
        m_ends++;
        k = m_ends / STEP;
        m_duty = (m_tgt > m_start) ? m_start + k : m_start - k;
        if (m_duty == m_tgt) m_busy = 0;
      end
      m_cnt = enable ? (m_cnt + 1) % (TOP + 1) : 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("duty",       int'(duty),       m_duty);
    chk("busy",       int'(busy),       int'(m_busy));
    chk("tgt_ready",  int'(tgt_ready),  int'(!m_busy));
    chk("pwm_out",    int'(pwm_out),    int'(enable && (m_cnt < m_duty)));
    chk("period_end", int'(period_end), int'(enable && (m_cnt == TOP)));
  endtask

  typedef struct {
    bit r; bit en; bit v; int td; int n;
    int e_duty; bit e_busy; bit e_ready;
  } vec_t;

  vec_t tbl[26];

  initial begin
    tbl[0]  = '{1, 1, 0,  0,   2,  0, 0, 1}; // reset
    tbl[1]  = '{0, 1, 0,  0,  32,  0, 0, 1}; // idle, pwm low
    tbl[2]  = '{0, 1, 1,  3,   1,  0, 1, 0}; // accept 3
    tbl[3]  = '{0, 1, 0,  0,  94,  2, 1, 0}; // one edge before final step
    tbl[4]  = '{0, 1, 0,  0,   1,  3, 0, 1}; // 6th period_end lands duty=3
    tbl[5]  = '{0, 1, 0,  0,  16,  3, 0, 1}; // steady 3/16
    tbl[6]  = '{0, 1, 1,  1,   1,  3, 1, 0}; // ramp down to 1
    tbl[7]  = '{0, 1, 1,  7,  63,  1, 0, 1}; // 7 held but blocked
    tbl[8]  = '{0, 1, 1,  7,   1,  1, 1, 0}; // 7 accepted first idle cycle
    tbl[9]  = '{0, 1, 0,  0, 191,  7, 0, 1}; // ramp 1->7
    tbl[10] = '{0, 1, 1,  7,   1,  7, 0, 1}; // no-op request
    tbl[11] = '{0, 1, 1,  3,   1,  7, 1, 0};
    tbl[12] = '{0, 1, 0,  0,  30,  6, 1, 0};
    tbl[13] = '{0, 1, 0,  0,  20,  6, 1, 0}; // pcnt now 1
    tbl[14] = '{0, 0, 0,  0,  40,  6, 1, 0}; // frozen
    tbl[15] = '{0, 1, 0,  0,  16,  5, 1, 0}; // resumes with pcnt kept
    tbl[16] = '{1, 1, 0,  0,   1,  0, 0, 1}; // reset mid-ramp
    tbl[17] = '{0, 0, 1, 14,   1,  0, 1, 0}; // accept while disabled
    tbl[18] = '{0, 0, 0,  0,   5,  0, 1, 0};
    tbl[19] = '{0, 1, 0,  0, 448, 14, 0, 1};
    tbl[20] = '{0, 1, 1, 15,   1, 14, 1, 0}; // full scale
    tbl[21] = '{0, 1, 0,  0,  31, 15, 0, 1};
    tbl[22] = '{0, 1, 0,  0,  16, 15, 0, 1};
    tbl[23] = '{0, 1, 1,  0,   1, 15, 1, 0};
    tbl[24] = '{0, 1, 0,  0, 479,  0, 0, 1}; // 30 period_ends down to 0
    tbl[25] = '{0, 1, 0,  0,  32,  0, 0, 1};

    foreach (tbl[i]) begin
      rst = tbl[i].r; enable = tbl[i].en; tgt_valid = tbl[i].v;
      tgt_duty = W'(tbl[i].td);
      for (int c = 0; c < tbl[i].n; c++) tick();
      chk($sformatf("tbl%0d_duty", i),  int'(duty),      tbl[i].e_duty);
      chk($sformatf("tbl%0d_busy", i),  int'(busy),      int'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_ready", i), int'(tgt_ready), int'(tbl[i].e_ready));
    end

    // Hand sequence: period_end spacing and a coincident-accept cycle.
    rst = 0; enable = 1; tgt_valid = 0;
    while (!period_end) tick();
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("pe_gap", int'(period_end), 0);
    end
    tick();
    chk("pe_16", int'(period_end), 1);
    tgt_valid = 1; tgt_duty = 2; // accepted on a period_end edge: not counted
    tick();
    tgt_valid = 0;
    for (int c = 0; c < 31; c++) tick();
    chk("coinc_duty", int'(duty), 0);
    tick();
    chk("coinc_duty_1", int'(duty), 1);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      enable    = ($urandom_range(0, 9) != 0);
      tgt_valid = ($urandom_range(0, 3) == 0);
      tgt_duty  = W'($urandom_range(0, TOP));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
